// File: rtl/i2s_mic_array.sv
// i2s_mic_array
//   Shared-clock I2S capture front end for NUM_MICS microphones. Generates a
//   single bit clock and word select for every mic, captures the left-slot
//   sample from all data lines in lockstep, and presents each frame as a
//   packed channel-aligned word plus the signed sum of the enabled channels
//   behind a ready/valid handshake with sticky overrun detection.
//
// Ports
//   clk_in        system audio clock
//   rst_in        synchronous, active-low reset
//   mic_data_in   raw asynchronous mic data pins (bit i = mic i)
//   chan_en_in    per-channel enable, sampled when a frame is latched
//   out_ready_in  consumer ready
//   bclk_out      shared bit clock
//   lrcl_out      shared word select (low = left slot)
//   samples_out   mic i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH], two's complement
//   sum_out       sign-extended sum of the enabled channels
//   out_valid_out frame valid
//   overrun_out   sticky: a frame was overwritten before being accepted
module i2s_mic_array #(
  parameter int NUM_MICS       = 3,
  parameter int SAMPLE_WIDTH   = 16,
  parameter int BCLK_DIV       = 32,
  parameter int BITS_PER_FRAME = 64,
  localparam int SUM_WIDTH     = SAMPLE_WIDTH + $clog2(NUM_MICS + 1)
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [NUM_MICS-1:0]              mic_data_in,
  input  logic [NUM_MICS-1:0]              chan_en_in,
  input  logic                             out_ready_in,
  output logic                             bclk_out,
  output logic                             lrcl_out,
  output logic [NUM_MICS*SAMPLE_WIDTH-1:0] samples_out,
  output logic [SUM_WIDTH-1:0]             sum_out,
  output logic                             out_valid_out,
  output logic                             overrun_out
);

  localparam int CYC_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(BITS_PER_FRAME);

  localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(BCLK_DIV - 1);
  localparam logic [CYC_W-1:0] CYC_HALF   = CYC_W'(BCLK_DIV / 2);
  localparam logic [CYC_W-1:0] CYC_STROBE = CYC_W'(3 * BCLK_DIV / 4);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(BITS_PER_FRAME - 1);
  localparam logic [BIT_W-1:0] BIT_HALF   = BIT_W'(BITS_PER_FRAME / 2);
  localparam logic [BIT_W-1:0] BIT_SAMPLE = BIT_W'(SAMPLE_WIDTH);

  logic [CYC_W-1:0] cyc_reg, cyc_next;
  logic [BIT_W-1:0] bit_reg, bit_next;
  logic             bclk_reg, lrcl_reg;
  logic [NUM_MICS-1:0] sync1_reg, sync2_reg;

  logic                             valid_reg, valid_next;
  logic                             overrun_reg, overrun_next;
  logic [NUM_MICS*SAMPLE_WIDTH-1:0] samples_reg, samples_next;
  logic signed [SUM_WIDTH-1:0]      sum_reg, sum_next;

  logic strobe;
  logic frame_done;

  // Bit-slot 0 is the I2S one-bit delay; only slots 1..SAMPLE_WIDTH carry data.
  assign strobe     = (cyc_reg == CYC_STROBE) && (bit_reg >= BIT_W'(1)) && (bit_reg <= BIT_SAMPLE);
  assign frame_done = strobe && (bit_reg == BIT_SAMPLE);

  always_comb begin
    cyc_next = cyc_reg + 1'b1;
    bit_next = bit_reg;
    if (cyc_reg == CYC_LAST) begin
      cyc_next = '0;
      bit_next = (bit_reg == BIT_LAST) ? '0 : bit_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cyc_reg   <= '0;
      bit_reg   <= '0;
      bclk_reg  <= 1'b0;
      lrcl_reg  <= 1'b0;
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      cyc_reg   <= cyc_next;
      bit_reg   <= bit_next;
      // Both clocks are decoded from the current count and registered, so
      // they trail the counters by one cycle and are glitch-free.
      bclk_reg  <= (cyc_reg >= CYC_HALF);
      lrcl_reg  <= (bit_reg >= BIT_HALF);
      sync1_reg <= mic_data_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Per-channel shift registers. The latched word is taken from the shift
  // value including the final bit, so data is visible one cycle after the
  // last strobe instead of two.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MICS; gi++) begin : g_chan
      logic [SAMPLE_WIDTH-1:0] shift_reg;
      logic [SAMPLE_WIDTH-1:0] shift_next;

      assign shift_next = {shift_reg[SAMPLE_WIDTH-2:0], sync2_reg[gi]};

      always_ff @(posedge clk_in) begin
        if (!rst_in) begin
          shift_reg <= '0;
        end else if (strobe) begin
          shift_reg <= shift_next;
        end
      end

      assign samples_next[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = chan_en_in[gi] ? shift_next : '0;
    end
  endgenerate

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < NUM_MICS; i++) begin
      sum_next = sum_next + SUM_WIDTH'(signed'(samples_next[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
    end
  end

  // A latch coinciding with a transfer is a clean hand-over; a latch while
  // the previous frame is still pending and not being taken is an overrun.
  always_comb begin
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    if (frame_done) begin
      valid_next = 1'b1;
      if (valid_reg && !out_ready_in) begin
        overrun_next = 1'b1;
      end
    end else if (valid_reg && out_ready_in) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      samples_reg <= '0;
      sum_reg     <= '0;
    end else begin
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
      if (frame_done) begin
        samples_reg <= samples_next;
        sum_reg     <= sum_next;
      end
    end
  end

  assign bclk_out      = bclk_reg;
  assign lrcl_out      = lrcl_reg;
  assign samples_out   = samples_reg;
  assign sum_out       = sum_reg;
  assign out_valid_out = valid_reg;
  assign overrun_out   = overrun_reg;

endmodule

// File: tb/tb_i2s_mic_array.sv
// tb_i2s_mic_array
//   Directed bench for i2s_mic_array. dut_a uses the default parameters with
//   three mic models; dut_b is the NUM_MICS=1, SAMPLE_WIDTH=24, BCLK_DIV=8
//   variant. Each mic model counts bclk rising edges while lrcl is low and
//   drives the next sample bit on each bclk falling edge (ones elsewhere).
module tb_i2s_mic_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // dut_a: defaults
  logic [2:0]  mic_a = '1;
  logic [2:0]  en_a;
  logic        ready_a;
  logic        bclk_a, lrcl_a, valid_a, overrun_a;
  logic [47:0] samples_a;
  logic [17:0] sum_a;

  // dut_b: parameter sweep
  logic [0:0]  mic_b = '1;
  logic [0:0]  en_b = 1'b1;
  logic        ready_b = 1'b1;
  logic        bclk_b, lrcl_b, valid_b, overrun_b;
  logic [23:0] samples_b;
  logic [24:0] sum_b;

  logic [15:0] mic_val [3];
  logic [23:0] mic_b_val = 24'h800000;

  i2s_mic_array dut_a (
    .clk_in(clk), .rst_in(rst_n), .mic_data_in(mic_a), .chan_en_in(en_a),
    .out_ready_in(ready_a), .bclk_out(bclk_a), .lrcl_out(lrcl_a),
    .samples_out(samples_a), .sum_out(sum_a), .out_valid_out(valid_a),
    .overrun_out(overrun_a)
  );

  i2s_mic_array #(.NUM_MICS(1), .SAMPLE_WIDTH(24), .BCLK_DIV(8), .BITS_PER_FRAME(64)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .mic_data_in(mic_b), .chan_en_in(en_b),
    .out_ready_in(ready_b), .bclk_out(bclk_b), .lrcl_out(lrcl_b),
    .samples_out(samples_b), .sum_out(sum_b), .out_valid_out(valid_b),
    .overrun_out(overrun_b)
  );

  // Mic models
  int   rise_a = 0;
  logic bq_a = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || lrcl_a) rise_a = 0;
    else if (!bq_a && bclk_a) rise_a++;
    if (bq_a && !bclk_a) begin
      for (int m = 0; m < 3; m++)
        mic_a[m] = (rise_a >= 1 && rise_a <= 16) ? mic_val[m][16 - rise_a] : 1'b1;
    end
    bq_a = bclk_a;
  end

  int   rise_b = 0;
  logic bq_b = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || lrcl_b) rise_b = 0;
    else if (!bq_b && bclk_b) rise_b++;
    if (bq_b && !bclk_b)
      mic_b[0] = (rise_b >= 1 && rise_b <= 24) ? mic_b_val[24 - rise_b] : 1'b1;
    bq_b = bclk_b;
  end

  int checks = 0;
  int errors = 0;
  int now = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance to the middle (negedge) of cycle n relative to the last release.
  task automatic goto(input int n);
    repeat (n - now) @(negedge clk);
    now = n;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_valid"},   64'(valid_a),   64'h0);
    check_val({tag, "_overrun"}, 64'(overrun_a), 64'h0);
    check_val({tag, "_samples"}, 64'(samples_a), 64'h0);
    check_val({tag, "_sum"},     64'(sum_a),     64'h0);
    check_val({tag, "_bclk"},    64'(bclk_a),    64'h0);
    check_val({tag, "_lrcl"},    64'(lrcl_a),    64'h0);
  endtask

  initial begin
    mic_val[0] = 16'h1234;
    mic_val[1] = 16'hFEDC;
    mic_val[2] = 16'h0001;
    en_a    = 3'b111;
    ready_a = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    now = 0;

    // Clock shape
    goto(16);  check_val("bclk_c16", 64'(bclk_a), 64'h0);
    goto(17);  check_val("bclk_c17", 64'(bclk_a), 64'h1);
    goto(32);  check_val("bclk_c32", 64'(bclk_a), 64'h1);
    goto(33);  check_val("bclk_c33", 64'(bclk_a), 64'h0);

    // Parameter sweep instance
    goto(198); check_val("b_valid_c198", 64'(valid_b), 64'h0);
    goto(199); check_val("b_valid_c199", 64'(valid_b), 64'h1);
               check_val("b_samples",    64'(samples_b), 64'h800000);
               check_val("b_sum",        64'(sum_b),     64'h1800000);

    // First frame, all enabled, ready high
    goto(536); check_val("valid_c536", 64'(valid_a), 64'h0);
    goto(537); check_val("valid_c537", 64'(valid_a), 64'h1);
               check_val("samples_f1", 64'(samples_a), 64'h0001_FEDC_1234);
               check_val("sum_f1",     64'(sum_a),     64'h01111);
               check_val("lrcl_c537",  64'(lrcl_a),    64'h0);
    goto(538); check_val("valid_c538", 64'(valid_a), 64'h0);
    goto(1024); check_val("lrcl_c1024", 64'(lrcl_a), 64'h0);
    goto(1025); check_val("lrcl_c1025", 64'(lrcl_a), 64'h1);
    goto(2048); check_val("lrcl_c2048", 64'(lrcl_a), 64'h1);
    goto(2049); check_val("lrcl_c2049", 64'(lrcl_a), 64'h0);
    goto(2584); check_val("valid_c2584", 64'(valid_a), 64'h0);
    goto(2585); check_val("valid_c2585", 64'(valid_a), 64'h1);
                check_val("samples_f2",  64'(samples_a), 64'h0001_FEDC_1234);
                check_val("overrun_f2",  64'(overrun_a), 64'h0);

    // Only channel 1 enabled
    goto(3000); en_a = 3'b010;
    goto(4633); check_val("en_valid",   64'(valid_a),   64'h1);
                check_val("en_samples", 64'(samples_a), 64'h0000_FEDC_0000);
                check_val("en_sum",     64'(sum_a),     64'h3FEDC);

    // Consumer stalled across two frames
    goto(5000); ready_a = 1'b0; en_a = 3'b111;
    goto(6681); check_val("stall_valid1",   64'(valid_a),   64'h1);
                check_val("stall_overrun1", 64'(overrun_a), 64'h0);
    goto(7000); mic_val[0] = 16'h0F0F;
    goto(8728); check_val("stall_overrun_pre", 64'(overrun_a), 64'h0);
    goto(8729); check_val("stall_overrun2", 64'(overrun_a), 64'h1);
                check_val("stall_valid2",   64'(valid_a),   64'h1);
                check_val("stall_samples2", 64'(samples_a), 64'h0001_FEDC_0F0F);
                check_val("stall_sum2",     64'(sum_a),     64'h00DEC);
    goto(9000); ready_a = 1'b1;
    goto(9001); check_val("drain_valid",   64'(valid_a),   64'h0);
                check_val("drain_overrun", 64'(overrun_a), 64'h1);

    // Reset 300 cycles into a frame
    goto(10540); rst_n = 1'b0;
    goto(10541); check_zero("midreset");
    goto(10544); rst_n = 1'b1;
    now = 0;
    ready_a = 1'b0;
    goto(300); check_val("rst_valid_c300", 64'(valid_a), 64'h0);
    goto(536); check_val("rst_valid_c536", 64'(valid_a), 64'h0);
    goto(537); check_val("rst_valid_c537", 64'(valid_a), 64'h1);
               check_val("rst_samples",    64'(samples_a), 64'h0001_FEDC_0F0F);

    // Transfer coinciding with the next latch: ready high only in the
    // strobe cycle whose closing edge loads the new frame.
    goto(1500); mic_val[0] = 16'h1234;
    goto(2584); ready_a = 1'b1;
    goto(2585); ready_a = 1'b0;
                check_val("same_valid",   64'(valid_a),   64'h1);
                check_val("same_samples", 64'(samples_a), 64'h0001_FEDC_1234);
                check_val("same_overrun", 64'(overrun_a), 64'h0);
    goto(2586); check_val("same_valid_hold",   64'(valid_a),   64'h1);
                check_val("same_overrun_hold", 64'(overrun_a), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
